// File: rtl/data_sync_pkg.sv
// Shared constants and edge-detect helper for the data_sync_param CDC synchronizer.
package data_sync_pkg;

  localparam int unsigned MODE_LEVEL      = 0;
  localparam int unsigned MODE_TOGGLE     = 1;
  localparam int unsigned MIN_SYNC_STAGES = 2;

  localparam int unsigned DEF_BUS_WIDTH  = 8;
  localparam int unsigned DEF_NUM_STAGES = 2;
  localparam int unsigned DEF_CNT_WIDTH  = 8;

  // Level mode fires on rising edges only; toggle mode fires on any change.
  function automatic logic edge_detect(input logic toggle_mode, input logic cur, input logic prev);
    return toggle_mode ? (cur ^ prev) : (cur & ~prev);
  endfunction

endpackage

// File: rtl/data_sync_param_sync_chain.sv
// NUM_STAGES-deep single-bit synchronizer flop chain, synchronous active-low reset.
module sync_chain
  import data_sync_pkg::*;
#(
  parameter int unsigned NUM_STAGES = DEF_NUM_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  generate
    if (NUM_STAGES < MIN_SYNC_STAGES) begin : g_bad_depth
      $error("sync_chain: NUM_STAGES must be at least %0d", MIN_SYNC_STAGES);
    end
  endgenerate

  logic [NUM_STAGES-1:0] s;

  always_ff @(posedge clk) begin
    if (!rst) s <= '0;
    else      s <= {s[NUM_STAGES-2:0], d};
  end

  assign q = s[NUM_STAGES-1];

endmodule

// File: rtl/data_sync_param.sv
// Qualifier-based multi-bit CDC synchronizer with capture counter and ack toggle.
// Optional bus-stability monitor enabled by defining DATA_SYNC_STABLE_CHECK_EN.
module data_sync_param
  import data_sync_pkg::*;
#(
  parameter int unsigned BUS_WIDTH   = DEF_BUS_WIDTH,
  parameter int unsigned NUM_STAGES  = DEF_NUM_STAGES,
  parameter int unsigned ENABLE_MODE = MODE_LEVEL,
  parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] Unsync_bus,
  input  logic                 bus_enable,
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic                 enable_pulse,
  output logic                 ack_toggle,
  output logic [CNT_WIDTH-1:0] capture_count,
  output logic                 bus_unstable
);

  generate
    if (NUM_STAGES < MIN_SYNC_STAGES) begin : g_bad_depth
      $error("data_sync_param: NUM_STAGES must be at least %0d", MIN_SYNC_STAGES);
    end
  endgenerate

  logic s_last;
  logic s_q;
  logic edge_det;

  sync_chain #(
    .NUM_STAGES(NUM_STAGES)
  ) u_chain (
    .clk(clk),
    .rst(rst),
    .d  (bus_enable),
    .q  (s_last)
  );

  assign edge_det = edge_detect(ENABLE_MODE == MODE_TOGGLE, s_last, s_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      s_q           <= 1'b0;
      sync_bus      <= '0;
      enable_pulse  <= 1'b0;
      ack_toggle    <= 1'b0;
      capture_count <= '0;
    end else begin
      s_q          <= s_last;
      enable_pulse <= edge_det;
      if (edge_det) begin
        sync_bus      <= Unsync_bus;
        ack_toggle    <= ~ack_toggle;
        capture_count <= capture_count + 1'b1;
      end
    end
  end

`ifdef DATA_SYNC_STABLE_CHECK_EN
  // sync_bus already holds the capture-cycle sample; compare it one cycle later.
  logic check_pending;

  always_ff @(posedge clk) begin
    if (!rst) begin
      check_pending <= 1'b0;
      bus_unstable  <= 1'b0;
    end else begin
      check_pending <= edge_det;
      if (check_pending && (Unsync_bus != sync_bus))
        bus_unstable <= 1'b1;
    end
  end
`else
  assign bus_unstable = 1'b0;
`endif

endmodule

// File: tb/tb_data_sync_param.sv
// Self-checking bench: a level-mode default instance and a toggle-mode 32-bit/3-stage/2-bit-counter instance.
module tb_data_sync_param;

  localparam int NA = 2;
  localparam int NB = 3;
  localparam int HMAX = 8192;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  bus_a = '0;
  logic        en_a  = 1'b0;
  logic [7:0]  sync_a;
  logic        pulse_a, ack_a, uns_a;
  logic [7:0]  cnt_a;

  logic [31:0] bus_b = '0;
  logic        en_b  = 1'b0;
  logic [31:0] sync_b;
  logic        pulse_b, ack_b, uns_b;
  logic [1:0]  cnt_b;

  data_sync_param u_dut_a (
    .clk(clk), .rst(rst), .Unsync_bus(bus_a), .bus_enable(en_a),
    .sync_bus(sync_a), .enable_pulse(pulse_a), .ack_toggle(ack_a),
    .capture_count(cnt_a), .bus_unstable(uns_a)
  );

  data_sync_param #(
    .BUS_WIDTH(32), .NUM_STAGES(NB), .ENABLE_MODE(1), .CNT_WIDTH(2)
  ) u_dut_b (
    .clk(clk), .rst(rst), .Unsync_bus(bus_b), .bus_enable(en_b),
    .sync_bus(sync_b), .enable_pulse(pulse_b), .ack_toggle(ack_b),
    .capture_count(cnt_b), .bus_unstable(uns_b)
  );

`ifdef DATA_SYNC_STABLE_CHECK_EN
  localparam bit STABLE_EN = 1'b1;
`else
  localparam bit STABLE_EN = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // History of what each rising edge saw; the model derives outputs from delays over it.
  bit en_a_h [HMAX];
  bit en_b_h [HMAX];
  bit rst_h  [HMAX];
  int cyc = 0;

  // Value reaching the last synchronizer stage after edge u: the enable sampled
  // NUM_STAGES-1 edges earlier, unless any reset fell inside that window.
  function automatic bit s_at(input bit which, input int u, input int n);
    if (u - n + 1 < 0) return 1'b0;
    for (int k = u - n + 1; k <= u; k++)
      if (!rst_h[k]) return 1'b0;
    return which ? en_b_h[u-n+1] : en_a_h[u-n+1];
  endfunction

  function automatic bit fires(input bit which, input int t, input int n, input bit toggle);
    bit a, b;
    a = s_at(which, t - 1, n);
    b = (t - 2 < 0 || !rst_h[t-1]) ? 1'b0 : s_at(which, t - 2, n);
    return toggle ? (a ^ b) : (a & ~b);
  endfunction

  logic [7:0]  m_bus_a;
  logic        m_pulse_a, m_ack_a, m_uns_a;
  int          m_cnt_a;
  logic [31:0] m_bus_b;
  logic        m_pulse_b, m_ack_b, m_uns_b;
  int          m_cnt_b;

  always @(posedge clk) begin
    bit fa, fb;
    if (cyc >= HMAX) $fatal(1, "FAIL history: cycle budget exceeded");
    en_a_h[cyc] = en_a;
    en_b_h[cyc] = en_b;
    rst_h[cyc]  = rst;
    if (!rst) begin
      m_bus_a = '0; m_pulse_a = 0; m_ack_a = 0; m_uns_a = 0; m_cnt_a = 0;
      m_bus_b = '0; m_pulse_b = 0; m_ack_b = 0; m_uns_b = 0; m_cnt_b = 0;
    end else begin
      fa = fires(1'b0, cyc, NA, 1'b0);
      fb = fires(1'b1, cyc, NB, 1'b1);
      if (STABLE_EN && m_pulse_a && bus_a != m_bus_a) m_uns_a = 1;
      if (STABLE_EN && m_pulse_b && bus_b != m_bus_b) m_uns_b = 1;
      m_pulse_a = fa;
      if (fa) begin m_bus_a = bus_a; m_ack_a = ~m_ack_a; m_cnt_a = (m_cnt_a + 1) % 256; end
      m_pulse_b = fb;
      if (fb) begin m_bus_b = bus_b; m_ack_b = ~m_ack_b; m_cnt_b = (m_cnt_b + 1) % 4; end
    end
    cyc++;
    #1;
    chk("a.sync_bus", 32'(sync_a), 32'(m_bus_a));
    chk("a.enable_pulse", 32'(pulse_a), 32'(m_pulse_a));
    chk("a.ack_toggle", 32'(ack_a), 32'(m_ack_a));
    chk("a.capture_count", 32'(cnt_a), 32'(m_cnt_a));
    chk("a.bus_unstable", 32'(uns_a), 32'(m_uns_a));
    chk("b.sync_bus", sync_b, m_bus_b);
    chk("b.enable_pulse", 32'(pulse_b), 32'(m_pulse_b));
    chk("b.ack_toggle", 32'(ack_b), 32'(m_ack_b));
    chk("b.capture_count", 32'(cnt_b), 32'(m_cnt_b));
    chk("b.bus_unstable", 32'(uns_b), 32'(m_uns_b));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] vals [5] = '{32'h1, 32'h2, 32'h3, 32'h4, 32'hDEADBEEF};

  initial begin
    tick(3);
    chk("lit.reset.sync_a", 32'(sync_a), 32'h0);
    chk("lit.reset.cnt_a", 32'(cnt_a), 32'h0);
    chk("lit.reset.pulse_b", 32'(pulse_b), 32'h0);
    rst = 1'b1;
    tick(2);

    // Level mode: one pulse, NUM_STAGES+1 edges after first sampling edge.
    bus_a = 8'hAA;
    en_a  = 1'b1;
    tick(NA);
    chk("lit.level.early_pulse", 32'(pulse_a), 32'h0);
    tick(1);
    chk("lit.level.pulse", 32'(pulse_a), 32'h1);
    chk("lit.level.sync", 32'(sync_a), 32'hAA);
    chk("lit.level.ack", 32'(ack_a), 32'h1);
    chk("lit.level.cnt", 32'(cnt_a), 32'h1);
    tick(1);
    chk("lit.level.one_cycle", 32'(pulse_a), 32'h0);
    tick(3);
    en_a = 1'b0;
    tick(6);
    chk("lit.level.fall_cnt", 32'(cnt_a), 32'h1);

    // Toggle mode, 3 stages, 2-bit counter: 1,2,3,0,1 and ack alternating.
    for (int i = 0; i < 5; i++) begin
      bus_b = vals[i];
      en_b  = ~en_b;
      tick(NB);
      chk("lit.toggle.early_pulse", 32'(pulse_b), 32'h0);
      tick(1);
      chk("lit.toggle.pulse", 32'(pulse_b), 32'h1);
      chk("lit.toggle.sync", sync_b, vals[i]);
      chk("lit.toggle.cnt", 32'(cnt_b), 32'((i + 1) % 4));
      chk("lit.toggle.ack", 32'(ack_b), 32'((i + 1) % 2));
      tick(10 - NB - 1);
    end
    bus_b = 32'h12345678;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("lit.hold32.sync", sync_b, 32'hDEADBEEF);
    end

    // Reset while an event is in flight, enable still high at release.
    bus_a = 8'h3C;
    en_a  = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("lit.midrst.pulse", 32'(pulse_a), 32'h0);
    chk("lit.midrst.cnt", 32'(cnt_a), 32'h0);
    chk("lit.midrst.ack", 32'(ack_a), 32'h0);
    chk("lit.midrst.sync", 32'(sync_a), 32'h0);
    tick(1);
    chk("lit.midrst.pulse2", 32'(pulse_a), 32'h0);
    rst = 1'b1;
    tick(NA);
    chk("lit.release.early", 32'(pulse_a), 32'h0);
    tick(1);
    chk("lit.release.pulse", 32'(pulse_a), 32'h1);
    chk("lit.release.sync", 32'(sync_a), 32'h3C);
    chk("lit.release.cnt", 32'(cnt_a), 32'h1);

    // Bus changes during the pulse cycle.
    en_a = 1'b0;
    tick(5);
    bus_a = 8'h55;
    en_a  = 1'b1;
    tick(NA + 1);
    chk("lit.stable.pulse", 32'(pulse_a), 32'h1);
    bus_a = 8'h56;
    tick(1);
    chk("lit.stable.set", 32'(uns_a), 32'(STABLE_EN));
    tick(5);
    chk("lit.stable.held", 32'(uns_a), 32'(STABLE_EN));
    rst = 1'b0;
    tick(1);
    chk("lit.stable.cleared", 32'(uns_a), 32'h0);
    rst = 1'b1;
    en_a = 1'b0;
    tick(4);

    // Randomized phase: model checks every cycle.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) en_a = ~en_a;
      if ($urandom_range(0, 2) == 0) en_b = ~en_b;
      if ($urandom_range(0, 1) == 0) bus_a = 8'($urandom);
      if ($urandom_range(0, 1) == 0) bus_b = $urandom;
      rst = ($urandom_range(0, 99) != 0);
      tick(1);
    end
    rst = 1'b1;
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
